// File: rtl/mem_arb_pkg.sv
// Shared constants for the port-B memory arbiter: FSM encoding, requester
// indices and the starvation counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_IO   = 1'b1;
  localparam int   STARVE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the port-B arbiter.
// MEM_ARB_RR_EN selects round-robin; otherwise fixed priority with a starvation override.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic starve_hit,
  input  logic last_winner,
  output logic win_valid,
  output logic win_idx
);

`ifdef MEM_ARB_RR_EN
  logic unused_starve_hit;
  assign unused_starve_hit = starve_hit;

  // On a tie, the requester that lost the previous grant goes next.
  always_comb begin
    win_valid = req0 | req1;
    if (req0 && req1) begin
      win_idx = ~last_winner;
    end else if (req1) begin
      win_idx = REQ_IO;
    end else begin
      win_idx = REQ_CPU;
    end
  end
`else
  logic unused_last_winner;
  assign unused_last_winner = last_winner;

  // The CPU wins ties unless the I/O side has been starved for too long.
  always_comb begin
    win_valid = req0 | req1;
    if (req1 && (starve_hit || !req0)) begin
      win_idx = REQ_IO;
    end else begin
      win_idx = REQ_CPU;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares RAM data port B between the CPU (requester 0) and the I/O engine (requester 1).
// MEM_ARB_RR_EN switches arbitration from fixed priority with starvation guard to round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             gnt0,
  output logic             rvalid0,
  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt1,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_q
);

  arb_state_e       state_q, state_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             starve_hit_s;
  logic             win_valid_s, win_idx_s;

`ifdef MEM_ARB_RR_EN
  localparam int unused_starve_max = STARVE_MAX;
  assign starve_hit_s = 1'b0;
`else
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  logic [STARVE_W-1:0] starve_q, starve_d;
  assign starve_hit_s = (starve_q >= STARVE_LIM);
`endif

  mem_arb_pick u_pick (
    .req0        (req0),
    .req1        (req1),
    .starve_hit  (starve_hit_s),
    .last_winner (last_q),
    .win_valid   (win_valid_s),
    .win_idx     (win_idx_s)
  );

  // Next-state and output computation for the IDLE -> ACCESS -> RESP cycle.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    owner_d     = owner_q;
    last_d      = last_q;
`ifndef MEM_ARB_RR_EN
    starve_d    = starve_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_valid_s) begin
          state_d     = ACCESS;
          mem_we_d    = (win_idx_s == REQ_IO) ? we1 : we0;
          mem_addr_d  = (win_idx_s == REQ_IO) ? addr1 : addr0;
          mem_wdata_d = (win_idx_s == REQ_IO) ? wdata1 : wdata0;
          gnt0_d      = (win_idx_s == REQ_CPU);
          gnt1_d      = (win_idx_s == REQ_IO);
          owner_d     = win_idx_s;
          last_d      = win_idx_s;
`ifndef MEM_ARB_RR_EN
          // Count CPU wins that pushed a waiting I/O request back; saturate.
          if (win_idx_s == REQ_IO) begin
            starve_d = {STARVE_W{1'b0}};
          end else if (req1 && (starve_q != {STARVE_W{1'b1}})) begin
            starve_d = starve_q + {{(STARVE_W-1){1'b0}}, 1'b1};
          end else begin
            starve_d = starve_q;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        rdata_d   = mem_q;
        rvalid0_d = (owner_q == REQ_CPU);
        rvalid1_d = (owner_q == REQ_IO);
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {WIDTH{1'b0}};
      mem_wdata_q <= {WIDTH{1'b0}};
      rdata_q     <= {WIDTH{1'b0}};
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      owner_q     <= 1'b0;
      last_q      <= 1'b0;
`ifndef MEM_ARB_RR_EN
      starve_q    <= {STARVE_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
`ifndef MEM_ARB_RR_EN
      starve_q    <= starve_d;
`endif
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata     = rdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
